// File: rtl/gravador_embarcacoes.sv
// gravador_embarcacoes
// Write side of the per-player ship-position memory. It stores one 8x8 ship
// bitmap per accepted request into the slot given by the ship index. On
// request it wipes all slots of one player. It also tracks which slots each
// player has filled since that player's last wipe.
//
// States:
//   state | meaning
//   IDLE  | waiting; clearReq wins over reqValid
//   WRITE | one-cycle write of the latched bitmap to the latched slot
//   CLEAR | eleven cycles of zero writes, one per slot, for the latched player
//
// Ports:
//   clk, resetGeral         clock, synchronous active-high reset
//   jogador                 target player (0 = one, 1 = two)
//   reqValid/reqReady       write request handshake
//   reqIndex, reqData       ship slot and bitmap
//   clearReq                level request to wipe the player's slots
//   memAddr, memData        registered memory write port
//   memWeJogadorUm/Dois     registered per-player write enables
//   busy                    not IDLE
//   errIndex                one-cycle pulse after an out-of-range index is accepted
//   placedMask, allPlaced   progress of the player currently on jogador
module gravador_embarcacoes #(
  parameter int NUM_EMBARCACOES = 11,
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 5
) (
  input  logic                       clk,
  input  logic                       resetGeral,
  input  logic                       jogador,
  input  logic                       reqValid,
  output logic                       reqReady,
  input  logic [3:0]                 reqIndex,
  input  logic [DATA_W-1:0]          reqData,
  input  logic                       clearReq,
  output logic [ADDR_W-1:0]          memAddr,
  output logic [DATA_W-1:0]          memData,
  output logic                       memWeJogadorUm,
  output logic                       memWeJogadorDois,
  output logic                       busy,
  output logic                       errIndex,
  output logic [NUM_EMBARCACOES-1:0] placedMask,
  output logic                       allPlaced
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_EMBARCACOES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                     state;
  logic                       jog_l;
  logic [3:0]                 idx_l;
  logic [3:0]                 cnt;
  logic [NUM_EMBARCACOES-1:0] mask_um;
  logic [NUM_EMBARCACOES-1:0] mask_dois;

  assign reqReady   = (state == IDLE) && !clearReq;
  assign busy       = (state != IDLE);
  assign placedMask = jogador ? mask_dois : mask_um;
  assign allPlaced  = (placedMask == {NUM_EMBARCACOES{1'b1}});

  // The memory port is registered. The address, data and enable for a write
  // are loaded on the edge that enters WRITE or CLEAR, or that advances CLEAR.
  // The write is therefore visible during the state that performs it.
  always_ff @(posedge clk) begin
    if (resetGeral) begin
      state            <= IDLE;
      jog_l            <= 1'b0;
      idx_l            <= '0;
      cnt              <= '0;
      memAddr          <= '0;
      memData          <= '0;
      memWeJogadorUm   <= 1'b0;
      memWeJogadorDois <= 1'b0;
      errIndex         <= 1'b0;
      mask_um          <= '0;
      mask_dois        <= '0;
    end else begin
      errIndex <= 1'b0;
      case (state)
        IDLE: begin
          if (clearReq) begin
            jog_l            <= jogador;
            cnt              <= '0;
            memAddr          <= '0;
            memData          <= '0;
            memWeJogadorUm   <= !jogador;
            memWeJogadorDois <= jogador;
            state            <= CLEAR;
          end else if (reqValid) begin
            jog_l <= jogador;
            idx_l <= reqIndex;
            if (reqIndex <= LAST_IDX) begin
              memAddr          <= ADDR_W'(reqIndex);
              memData          <= reqData;
              memWeJogadorUm   <= !jogador;
              memWeJogadorDois <= jogador;
              state            <= WRITE;
            end else begin
              // The request is consumed without a write. The port keeps its
              // previous values.
              errIndex <= 1'b1;
            end
          end
        end
        WRITE: begin
          memWeJogadorUm   <= 1'b0;
          memWeJogadorDois <= 1'b0;
          if (jog_l) mask_dois[idx_l] <= 1'b1;
          else       mask_um[idx_l]   <= 1'b1;
          state <= IDLE;
        end
        CLEAR: begin
          if (cnt == LAST_IDX) begin
            memWeJogadorUm   <= 1'b0;
            memWeJogadorDois <= 1'b0;
            if (jog_l) mask_dois <= '0;
            else       mask_um   <= '0;
            state <= IDLE;
          end else begin
            cnt     <= cnt + 4'd1;
            memAddr <= ADDR_W'(cnt + 4'd1);
          end
        end
        default: begin
          memWeJogadorUm   <= 1'b0;
          memWeJogadorDois <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gravador_embarcacoes.sv
module tb_gravador_embarcacoes;

  logic        clk = 1'b0;
  logic        resetGeral;
  logic        jogador;
  logic        reqValid;
  logic        reqReady;
  logic [3:0]  reqIndex;
  logic [63:0] reqData;
  logic        clearReq;
  logic [4:0]  memAddr;
  logic [63:0] memData;
  logic        memWeJogadorUm;
  logic        memWeJogadorDois;
  logic        busy;
  logic        errIndex;
  logic [10:0] placedMask;
  logic        allPlaced;

  gravador_embarcacoes dut (
    .clk              (clk),
    .resetGeral       (resetGeral),
    .jogador          (jogador),
    .reqValid         (reqValid),
    .reqReady         (reqReady),
    .reqIndex         (reqIndex),
    .reqData          (reqData),
    .clearReq         (clearReq),
    .memAddr          (memAddr),
    .memData          (memData),
    .memWeJogadorUm   (memWeJogadorUm),
    .memWeJogadorDois (memWeJogadorDois),
    .busy             (busy),
    .errIndex         (errIndex),
    .placedMask       (placedMask),
    .allPlaced        (allPlaced)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pl;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   exp_errp = 0;
  int   seen_errp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every write-enable cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (errIndex === 1'b1) seen_errp++;
    if (memWeJogadorUm === 1'b1 || memWeJogadorDois === 1'b1) begin
      exp_t e;
      chk("we_exclusive", 64'(memWeJogadorUm & memWeJogadorDois), 64'd0);
      if (q.size() == 0) begin
        chk("spurious_we", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("wr_player", 64'(memWeJogadorDois), 64'(e.pl));
        chk("wr_addr", 64'(memAddr), 64'(e.addr));
        chk("wr_data", memData, e.data);
      end
    end
  end

  // Hold a request until the DUT takes it (bounded), then record the expected effect.
  task automatic send(input logic pl, input logic [3:0] idx, input logic [63:0] d, input bit keep);
    logic rdy;
    bit   ok;
    exp_t e;
    ok = 1'b0;
    jogador  = pl;
    reqIndex = idx;
    reqData  = d;
    reqValid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      rdy = reqReady;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      last_acc = cyc;
      if (idx <= 4'd10) begin
        e.pl = pl; e.addr = 5'(idx); e.data = d;
        q.push_back(e);
      end else begin
        exp_errp++;
      end
    end
    if (!keep) reqValid = 1'b0;
  endtask

  task automatic push_clear(input logic pl, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pl = pl; e.addr = 5'(i); e.data = 64'd0;
      q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int          prev;
    int          clr_start;
    logic [63:0] da, db;

    resetGeral = 1'b1;
    jogador    = 1'b0;
    reqValid   = 1'b0;
    reqIndex   = '0;
    reqData    = '0;
    clearReq   = 1'b0;
    repeat (3) tick();
    resetGeral = 1'b0;

    // Reset state
    chk("rst_addr", 64'(memAddr), 64'd0);
    chk("rst_data", memData, 64'd0);
    chk("rst_we", 64'({memWeJogadorUm, memWeJogadorDois}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(reqReady), 64'd1);
    chk("rst_mask", 64'(placedMask), 64'd0);
    chk("rst_all", 64'(allPlaced), 64'd0);
    chk("rst_err", 64'(errIndex), 64'd0);

    // Single write, player one, slot 3
    send(1'b0, 4'd3, 64'h18, 1'b0);
    chk("w1_we_um", 64'(memWeJogadorUm), 64'd1);
    chk("w1_we_dois", 64'(memWeJogadorDois), 64'd0);
    chk("w1_addr", 64'(memAddr), 64'd3);
    chk("w1_data", memData, 64'h18);
    chk("w1_busy", 64'(busy), 64'd1);
    tick();
    chk("w1_mask", 64'(placedMask), 64'h008);
    chk("w1_busy_fall", 64'(busy), 64'd0);

    // Fill all slots of player two back to back
    for (int i = 0; i <= 10; i++) begin
      prev = last_acc;
      send(1'b1, 4'(i), {$urandom, $urandom}, (i < 10));
      if (i > 0) chk("acc_interval", 64'(last_acc - prev), 64'd2);
    end
    tick();
    chk("fill_all", 64'(allPlaced), 64'd1);
    chk("fill_mask", 64'(placedMask), 64'h7FF);
    jogador = 1'b0;
    #1;
    chk("fill_other_mask", 64'(placedMask), 64'h008);
    chk("fill_other_all", 64'(allPlaced), 64'd0);

    // Out-of-range indices
    send(1'b0, 4'd11, 64'hDEAD, 1'b0);
    chk("bad11_err", 64'(errIndex), 64'd1);
    chk("bad11_busy", 64'(busy), 64'd0);
    tick();
    chk("bad11_err_fall", 64'(errIndex), 64'd0);
    chk("bad11_mask", 64'(placedMask), 64'h008);
    send(1'b0, 4'd15, 64'hBEEF, 1'b0);
    chk("bad15_err", 64'(errIndex), 64'd1);
    tick();
    chk("bad15_err_fall", 64'(errIndex), 64'd0);
    chk("bad15_mask", 64'(placedMask), 64'h008);

    // Overwrite slot 9 of player one
    da = 64'h0102_0304_0506_0708;
    db = 64'hF0E0_D0C0_B0A0_9080;
    send(1'b0, 4'd9, da, 1'b0);
    tick();
    chk("ow1_mask", 64'(placedMask), 64'h208);
    send(1'b0, 4'd9, db, 1'b0);
    chk("ow2_data", memData, db);
    chk("ow2_addr", 64'(memAddr), 64'd9);
    tick();
    chk("ow2_mask", 64'(placedMask), 64'h208);

    // Clear of player two with a competing request held
    jogador  = 1'b1;
    clearReq = 1'b1;
    reqValid = 1'b1;
    reqIndex = 4'd2;
    reqData  = 64'h0000_0000_0000_0700;
    push_clear(1'b1, 11);
    @(negedge clk);
    chk("clr_ready_low", 64'(reqReady), 64'd0);
    tick();
    clr_start = cyc;
    chk("clr_busy", 64'(busy), 64'd1);
    clearReq = 1'b0;
    jogador  = 1'b0;
    tick();
    tick();
    jogador = 1'b1;
    send(1'b1, 4'd2, 64'h0000_0000_0000_0700, 1'b0);
    chk("clr_len", 64'(last_acc - clr_start), 64'd12);
    tick();
    chk("clr_mask_after", 64'(placedMask), 64'h004);
    jogador = 1'b0;
    #1;
    chk("clr_other_mask", 64'(placedMask), 64'h208);
    chk("sb_empty_clr", 64'(q.size()), 64'd0);

    // Reset in the middle of a clear of player one
    jogador  = 1'b0;
    clearReq = 1'b1;
    push_clear(1'b0, 6);
    tick();
    clearReq = 1'b0;
    repeat (5) tick();
    chk("mid_addr5", 64'(memAddr), 64'd5);
    resetGeral = 1'b1;
    tick();
    resetGeral = 1'b0;
    chk("mid_we", 64'({memWeJogadorUm, memWeJogadorDois}), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_mask_um", 64'(placedMask), 64'd0);
    jogador = 1'b1;
    #1;
    chk("mid_mask_dois", 64'(placedMask), 64'd0);
    tick();
    chk("mid_we_next", 64'({memWeJogadorUm, memWeJogadorDois}), 64'd0);
    repeat (3) tick();

    chk("sb_empty_end", 64'(q.size()), 64'd0);
    chk("err_pulses", 64'(seen_errp), 64'(exp_errp));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
